endec_seq_ctrl: RTL
===================

// Module: endec_seq_ctrl
// PURPOSE
// - Parametrised sequencing controller for the conv encoder / Viterbi decoder datapath; supersedes the fixed-schedule stage controller.
// - Accepts symbols on a valid/ready stream and runs encode or decode frames of FRAME_LEN symbols.
// - Generates per-stage enables (CE, S, BM, ACS, TD, T) with a pipelined schedule, a TB_DEPTH traceback phase and a held-output handshake.
// PARAMETERS
// - FRAME_LEN  8  symbols per frame (decoder output width)
// - TB_DEPTH   8  traceback cycles per decode frame, >=1
// - PIPE_LAT   4  S->BM->ACS->TD stage count; fixed at 4 in this revision
// PORTS
// - sys_clk       in   1   clock, rising edge
// - rst           in   1   asynchronous, active-high reset
// - i_mode_sel    in   1   0 encode, 1 decode; latched on first accepted symbol
// - i_code_rate   in   1   0 rate 1/2, 1 rate 1/3; latched with i_mode_sel
// - i_constr_len  in   2   K = i_constr_len+3; latched with i_mode_sel
// - i_valid       in   1   input symbol valid
// - o_ready       out  1   controller can accept a symbol
// - i_flush       in   1   synchronous frame abort
// - i_out_ready   in   1   consumer accepts decoded frame
// - o_out_valid   out  1   decoded frame held valid
// - o_en_ce, o_en_s, o_en_bm, o_en_acs, o_en_td, o_en_t  out  1 each  stage enables
// - o_tail        out  1   encoder fed zero tail bit (ENDEC_TAIL_FLUSH_EN only; else tied 0)
// - o_code_rate_q out  1   latched code rate
// - o_sym_cnt     out  $clog2(FRAME_LEN+1)  symbols accepted this frame
// - o_busy        out  1   state != IDLE
// - o_frame_done  out  1   one-cycle completion pulse
// BEHAVIOUR
// - Reset: state IDLE; all enables, o_out_valid, o_tail, o_frame_done, o_busy, o_sym_cnt, o_code_rate_q = 0; o_ready = 0 while rst high.
// - States: IDLE, ENC, ENC_TAIL, DEC_FILL, DEC_DRAIN, DEC_TB, HOLD.
// - Accept = i_valid & o_ready. o_ready = !i_flush & (IDLE | ((ENC|DEC_FILL) & o_sym_cnt<FRAME_LEN)).
// - IDLE: accept latches mode/rate/K, o_sym_cnt<=1, go ENC (mode 0) or DEC_FILL (mode 1). FRAME_LEN==1: go straight to ENC-end / DEC_DRAIN.
// - ENC: each accept at cycle t -> o_en_ce=1 at t+1 (registered). Last accept -> frame end: o_frame_done at t+2, then IDLE.
// - DEC_FILL: accept at t -> o_en_s t+1, o_en_bm t+2, o_en_acs t+3, o_en_td t+4 (4-bit shift register; gaps in i_valid propagate as gaps).
// - Last decode accept at N -> DEC_DRAIN N+1..N+4, DEC_TB N+5..N+4+TB_DEPTH with o_en_t=1, HOLD from N+5+TB_DEPTH.
// - HOLD: o_out_valid=1, stable until i_out_ready; handshake cycle -> o_frame_done=1 next cycle, IDLE, o_out_valid=0. New frame acceptable in that IDLE cycle.
// - o_sym_cnt saturates at FRAME_LEN; cleared on entry to IDLE. TB counter $clog2(TB_DEPTH+1) bits, reloaded on DEC_TB entry.
// - i_flush (any state): next cycle IDLE, all enables and shift register cleared, o_out_valid=0, no o_frame_done; flush beats accept in same cycle.
// - i_valid while !o_ready: ignored, no state change. Latched mode/rate/K never change mid-frame.
// - rst mid-frame: immediate return to reset values, no done pulse.
// CONFIGURATION
// - ENDEC_TAIL_FLUSH_EN defined: after last ENC bit's o_en_ce, state ENC_TAIL drives o_en_ce=1 and o_tail=1 for K-1 cycles (K from latched i_constr_len); o_frame_done the cycle after the last tail cycle; o_ready=0 during ENC_TAIL.
// - ENDEC_TAIL_FLUSH_EN undefined: ENC_TAIL absent, o_tail tied 0, timing as in BEHAVIOUR.
// TESTING (FRAME_LEN=8, TB_DEPTH=8)
// - Reset then idle: all outputs 0, o_ready=1 after rst falls; assert rst mid-DEC_TB -> outputs return to 0 same cycle.
// - Encode, 8 back-to-back bits cycles 0..7 -> o_en_ce cycles 1..8, o_frame_done cycle 9, o_ready low cycles 8..9 only when o_sym_cnt==8.
// - Decode, 8 back-to-back symbols 0..7 -> en_s 1..8, en_td 4..11, en_t 12..19, o_out_valid from 20; i_out_ready at 23 -> o_frame_done 24, o_out_valid 0 at 24.
// - Decode with i_valid gaps (symbols at 0,2,5..10) -> stage enables replicate gap pattern shifted 1..4 cycles; o_sym_cnt=8 after cycle 10.
// - i_flush in DEC_DRAIN with simultaneous i_valid -> IDLE next cycle, no o_frame_done, symbol not counted; following frame runs normally.
// - ENDEC_TAIL_FLUSH_EN, i_constr_len=2 (K=5): 8 bits cycles 0..7 -> o_en_ce 1..12, o_tail 9..12, o_frame_done 13.

Source files
------------

// File: rtl/endec_seq_ctrl.sv
// endec_seq_ctrl: valid/ready sequencing controller for the conv encoder / Viterbi decoder stage enables.
// Define ENDEC_TAIL_FLUSH_EN to append K-1 zero-tail encoder cycles after each encode frame.
module endec_seq_ctrl #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned TB_DEPTH  = 8,
    parameter int unsigned PIPE_LAT  = 4
) (
    input  logic                             sys_clk,
    input  logic                             rst,
    input  logic                             i_mode_sel,
    input  logic                             i_code_rate,
    input  logic [1:0]                       i_constr_len,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic                             i_flush,
    input  logic                             i_out_ready,
    output logic                             o_out_valid,
    output logic                             o_en_ce,
    output logic                             o_en_s,
    output logic                             o_en_bm,
    output logic                             o_en_acs,
    output logic                             o_en_td,
    output logic                             o_en_t,
    output logic                             o_tail,
    output logic                             o_code_rate_q,
    output logic [$clog2(FRAME_LEN+1)-1:0]   o_sym_cnt,
    output logic                             o_busy,
    output logic                             o_frame_done
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned TB_W  = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN);

    typedef enum logic [2:0] {
        IDLE, ENC, ENC_TAIL, DEC_FILL, DEC_DRAIN, DEC_TB, HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PIPE_LAT-1:0]   pipe_q, pipe_d;
    logic                  en_ce_q, en_ce_d;
    logic [TB_W-1:0]       tb_cnt_q, tb_cnt_d;
    logic                  rate_q, rate_d;
    logic                  dec_done_q, dec_done_d;
    logic                  accept;
    logic                  cnt_full;
    logic                  enc_done;

`ifdef ENDEC_TAIL_FLUSH_EN
    logic [1:0]            k_q, k_d;
    logic [2:0]            tail_cnt_q, tail_cnt_d;
`else
    logic                  unused_constr;
    always_comb unused_constr = ^i_constr_len;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pipe_q     <= '0;
            en_ce_q    <= 1'b0;
            tb_cnt_q   <= '0;
            rate_q     <= 1'b0;
            dec_done_q <= 1'b0;
`ifdef ENDEC_TAIL_FLUSH_EN
            k_q        <= '0;
            tail_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pipe_q     <= pipe_d;
            en_ce_q    <= en_ce_d;
            tb_cnt_q   <= tb_cnt_d;
            rate_q     <= rate_d;
            dec_done_q <= dec_done_d;
`ifdef ENDEC_TAIL_FLUSH_EN
            k_q        <= k_d;
            tail_cnt_q <= tail_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pipe_d     = {pipe_q[PIPE_LAT-2:0], 1'b0};
        en_ce_d    = 1'b0;
        tb_cnt_d   = tb_cnt_q;
        rate_d     = rate_q;
        dec_done_d = 1'b0;
        accept     = i_valid & o_ready;
`ifdef ENDEC_TAIL_FLUSH_EN
        k_d        = k_q;
        tail_cnt_d = tail_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rate_d = i_code_rate;
                    cnt_d  = CNT_W'(1);
`ifdef ENDEC_TAIL_FLUSH_EN
                    k_d    = i_constr_len;
`endif
                    if (i_mode_sel) begin
                        pipe_d[0] = 1'b1;
                        state_d   = (FRAME_LEN == 1) ? DEC_DRAIN : DEC_FILL;
                    end else begin
                        en_ce_d = 1'b1;
                        state_d = ENC;
                    end
                end
            end
            ENC: begin
                if (accept) begin
                    en_ce_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`ifdef ENDEC_TAIL_FLUSH_EN
                if (cnt_full && en_ce_q) begin
                    state_d    = ENC_TAIL;
                    tail_cnt_d = {1'b0, k_q} + 3'd2;
                end
`else
                if (cnt_full && !en_ce_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`endif
            end
`ifdef ENDEC_TAIL_FLUSH_EN
            ENC_TAIL: begin
                if (tail_cnt_q != 3'd0) begin
                    tail_cnt_d = tail_cnt_q - 3'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
`endif
            DEC_FILL: begin
                if (accept) begin
                    pipe_d[0] = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_MAX - CNT_W'(1)) state_d = DEC_DRAIN;
                end
            end
            DEC_DRAIN: begin
                // No accepts after the last symbol, so its bit alone in the top slot marks the drained pipe.
                if (pipe_q[PIPE_LAT-1] && (pipe_q[PIPE_LAT-2:0] == '0)) begin
                    state_d  = DEC_TB;
                    tb_cnt_d = TB_W'(TB_DEPTH);
                end
            end
            DEC_TB: begin
                if (tb_cnt_q == TB_W'(1)) state_d = HOLD;
                else                      tb_cnt_d = tb_cnt_q - TB_W'(1);
            end
            HOLD: begin
                if (i_out_ready) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    dec_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (i_flush) begin
            state_d    = IDLE;
            cnt_d      = '0;
            pipe_d     = '0;
            en_ce_d    = 1'b0;
            dec_done_d = 1'b0;
        end
    end

    always_comb begin
        cnt_full      = (cnt_q == CNT_MAX);
        o_ready       = !rst && !i_flush &&
                        ((state_q == IDLE) ||
                         (((state_q == ENC) || (state_q == DEC_FILL)) && !cnt_full));
        o_en_s        = pipe_q[0];
        o_en_bm       = pipe_q[1];
        o_en_acs      = pipe_q[2];
        o_en_td       = pipe_q[PIPE_LAT-1];
        o_en_t        = (state_q == DEC_TB);
        o_out_valid   = (state_q == HOLD);
        o_busy        = (state_q != IDLE);
        o_sym_cnt     = cnt_q;
        o_code_rate_q = rate_q;
`ifdef ENDEC_TAIL_FLUSH_EN
        o_tail        = (state_q == ENC_TAIL) && (tail_cnt_q != 3'd0);
        o_en_ce       = en_ce_q || o_tail;
        enc_done      = (state_q == ENC_TAIL) && (tail_cnt_q == 3'd0);
`else
        o_tail        = 1'b0;
        o_en_ce       = en_ce_q;
        enc_done      = (state_q == ENC) && cnt_full && !en_ce_q;
`endif
        o_frame_done  = enc_done || dec_done_q;
    end

endmodule
